// File: rtl/program_loader_if.sv
// Loader bus: RX byte stream in, IRAM/DRAM write ports and CPU run handshake out.
// The loader takes the slave view; the host/environment takes the master view.
interface program_loader_if #(
   parameter int IADDR_W = 8,
   parameter int DADDR_W = 16
);
   logic [7:0]         RX_DATA;
   logic               RX_VALID;
   logic               RX_READY;
   logic               IRAM_WE;
   logic [IADDR_W-1:0] IRAM_ADDR;
   logic [7:0]         IRAM_DATA;
   logic               DRAM_WE;
   logic [DADDR_W-1:0] DRAM_ADDR;
   logic [7:0]         DRAM_DATA;
   logic               START_PROCESSING_FLAG;
   logic               PROCESS_FINISHED;
   logic               LOAD_ERROR;
   logic               BUSY;

   modport slave (
      input  RX_DATA, RX_VALID, PROCESS_FINISHED,
      output RX_READY, IRAM_WE, IRAM_ADDR, IRAM_DATA, DRAM_WE, DRAM_ADDR, DRAM_DATA,
             START_PROCESSING_FLAG, LOAD_ERROR, BUSY
   );

   modport master (
      output RX_DATA, RX_VALID, PROCESS_FINISHED,
      input  RX_READY, IRAM_WE, IRAM_ADDR, IRAM_DATA, DRAM_WE, DRAM_ADDR, DRAM_DATA,
             START_PROCESSING_FLAG, LOAD_ERROR, BUSY
   );
endinterface

// File: rtl/program_loader.sv
// Frame parser that loads instruction/data RAM from a byte stream and
// hands control to the CPU on a GO command until it reports completion.
module program_loader #(
   parameter int IADDR_W = 8,
   parameter int DADDR_W = 16,
   parameter int TIMEOUT = 50000
) (
   input  logic            MAIN_CLOCK,
   input  logic            RESET,
   program_loader_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE, S_LEN_H, S_LEN_L, S_ADR_H, S_ADR_L, S_PAYLOAD, S_CHK, S_RUN
   } state_t;

   // Counter only needs to hold TIMEOUT-1; the compare is skipped when TIMEOUT is 0.
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] TMAX = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   state_t        state_q, state_d;
   logic [15:0]   len_q, len_d;
   logic [15:0]   addr_q, addr_d;
   logic [7:0]    chk_q, chk_d;
   logic          isd_q, isd_d;
   logic          err_q, err_d;
   logic          iwe_q, iwe_d;
   logic          dwe_q, dwe_d;
   logic [15:0]   waddr_q, waddr_d;
   logic [7:0]    wdata_q, wdata_d;
   logic          start_q, start_d;
   logic [TW-1:0] tcnt_q, tcnt_d;

   logic       acc;
   logic       in_frame;
   logic [7:0] rx_byte;

   assign rx_byte  = bus.RX_DATA;
   assign acc      = bus.RX_VALID && (state_q != S_RUN);
   assign in_frame = (state_q != S_IDLE) && (state_q != S_RUN);

   always_ff @(posedge MAIN_CLOCK or posedge RESET) begin
      if (RESET) begin
         state_q <= S_IDLE;
         len_q   <= '0;
         addr_q  <= '0;
         chk_q   <= '0;
         isd_q   <= 1'b0;
         err_q   <= 1'b0;
         iwe_q   <= 1'b0;
         dwe_q   <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
         start_q <= 1'b0;
         tcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         addr_q  <= addr_d;
         chk_q   <= chk_d;
         isd_q   <= isd_d;
         err_q   <= err_d;
         iwe_q   <= iwe_d;
         dwe_q   <= dwe_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
         start_q <= start_d;
         tcnt_q  <= tcnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      addr_d  = addr_q;
      chk_d   = chk_q;
      isd_d   = isd_q;
      err_d   = err_q;
      iwe_d   = 1'b0;
      dwe_d   = 1'b0;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      start_d = 1'b0;
      tcnt_d  = '0;

      case (state_q)
         S_IDLE: if (acc) begin
            err_d = 1'b0;
            chk_d = rx_byte;
            case (rx_byte)
               8'h49: begin isd_d = 1'b0; state_d = S_LEN_H; end
               8'h44: begin isd_d = 1'b1; state_d = S_LEN_H; end
               8'h47: begin start_d = 1'b1; state_d = S_RUN; end
               default: err_d = 1'b1;
            endcase
         end
         S_LEN_H: if (acc) begin
            len_d   = {rx_byte, 8'h00};
            chk_d   = chk_q ^ rx_byte;
            state_d = S_LEN_L;
         end
         S_LEN_L: if (acc) begin
            len_d   = {len_q[15:8], rx_byte};
            chk_d   = chk_q ^ rx_byte;
            state_d = S_ADR_H;
         end
         S_ADR_H: if (acc) begin
            addr_d  = {rx_byte, 8'h00};
            chk_d   = chk_q ^ rx_byte;
            state_d = S_ADR_L;
         end
         S_ADR_L: if (acc) begin
            addr_d  = {addr_q[15:8], rx_byte};
            chk_d   = chk_q ^ rx_byte;
            state_d = (len_q == 16'd0) ? S_CHK : S_PAYLOAD;
         end
         S_PAYLOAD: if (acc) begin
            iwe_d   = ~isd_q;
            dwe_d   = isd_q;
            waddr_d = addr_q;
            wdata_d = rx_byte;
            addr_d  = addr_q + 16'd1;
            len_d   = len_q - 16'd1;
            chk_d   = chk_q ^ rx_byte;
            if (len_q == 16'd1) state_d = S_CHK;
         end
         S_CHK: if (acc) begin
            if (rx_byte != chk_q) err_d = 1'b1;
            state_d = S_IDLE;
         end
         S_RUN: begin
            // START stays high through the cycle in which FINISHED is sampled.
            start_d = 1'b1;
            if (bus.PROCESS_FINISHED) begin
               start_d = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (in_frame && !acc) begin
         tcnt_d = tcnt_q + 1'b1;
         if ((TIMEOUT != 0) && (tcnt_q == TMAX)) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
            tcnt_d  = '0;
         end
      end
   end

   assign bus.RX_READY              = ~RESET && (state_q != S_RUN);
   assign bus.IRAM_WE               = iwe_q;
   assign bus.IRAM_ADDR             = waddr_q[IADDR_W-1:0];
   assign bus.IRAM_DATA             = wdata_q;
   assign bus.DRAM_WE               = dwe_q;
   assign bus.DRAM_ADDR             = waddr_q[DADDR_W-1:0];
   assign bus.DRAM_DATA             = wdata_q;
   assign bus.START_PROCESSING_FLAG = start_q;
   assign bus.LOAD_ERROR            = err_q;
   assign bus.BUSY                  = (state_q != S_IDLE);

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: RAM writes are queued as frames are driven
// and checked as the strobes appear; control outputs are checked inline per scenario.
module tb_program_loader;

   localparam int IW = 8;
   localparam int DW = 16;
   localparam int TO = 20;

   typedef struct packed {
      logic        is_d;
      logic [15:0] addr;
      logic [7:0]  data;
   } wr_t;

   logic clk;
   logic RESET;
   int   total;
   int   bad;
   wr_t  expq[$];
   logic [7:0] pl[$];

   program_loader_if #(.IADDR_W(IW), .DADDR_W(DW)) bus ();

   program_loader #(.IADDR_W(IW), .DADDR_W(DW), .TIMEOUT(TO)) dut (
      .MAIN_CLOCK(clk),
      .RESET     (RESET),
      .bus       (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
      $fatal(1, "watchdog");
   end

   // Write monitor: every strobe must match the head of the expected queue.
   always @(negedge clk) begin
      if (!RESET && (bus.IRAM_WE || bus.DRAM_WE)) begin
         wr_t act;
         wr_t exp;
         act.is_d = bus.DRAM_WE;
         act.addr = bus.DRAM_WE ? bus.DRAM_ADDR : {8'h00, bus.IRAM_ADDR};
         act.data = bus.DRAM_WE ? bus.DRAM_DATA : bus.IRAM_DATA;
         total++;
         if (bus.IRAM_WE && bus.DRAM_WE) begin
            bad++;
            $display("FAIL both_we: IRAM_WE and DRAM_WE high together");
         end else if (expq.size() == 0) begin
            bad++;
            $display("FAIL unexpected_write: got d=%0b addr=%h data=%h, none expected",
                     act.is_d, act.addr, act.data);
         end else begin
            exp = expq.pop_front();
            if (act !== exp) begin
               bad++;
               $display("FAIL ram_write: got d=%0b addr=%h data=%h, want d=%0b addr=%h data=%h",
                        act.is_d, act.addr, act.data, exp.is_d, exp.addr, exp.data);
            end
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      bus.RX_DATA  = b;
      bus.RX_VALID = 1'b1;
      while (bus.RX_READY !== 1'b1 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 200) begin
         total++; bad++;
         $display("FAIL rx_ready_timeout: byte %h not accepted in 200 cycles", b);
      end
      @(posedge clk); #1;
      bus.RX_VALID = 1'b0;
   endtask

   // Sends cmd/len/addr/payload(pl)/chk; queues the expected RAM writes.
   task automatic send_frame(input logic [7:0] cmd, input logic [15:0] addr,
                             input bit corrupt_chk);
      logic [15:0] len;
      logic [7:0]  chk;
      wr_t         w;
      len = 16'(pl.size());
      chk = cmd ^ len[15:8] ^ len[7:0] ^ addr[15:8] ^ addr[7:0];
      send_byte(cmd);
      send_byte(len[15:8]);
      send_byte(len[7:0]);
      send_byte(addr[15:8]);
      send_byte(addr[7:0]);
      for (int i = 0; i < pl.size(); i++) begin
         w.is_d = (cmd == 8'h44);
         w.addr = addr + 16'(i);
         if (!w.is_d) w.addr = {8'h00, w.addr[7:0]};
         w.data = pl[i];
         expq.push_back(w);
         chk = chk ^ pl[i];
         send_byte(pl[i]);
      end
      send_byte(corrupt_chk ? ~chk : chk);
   endtask

   task automatic drain(input string name);
      repeat (3) begin @(posedge clk); #1; end
      total++;
      if (expq.size() !== 0) begin
         bad++;
         $display("FAIL %s_pending: %0d writes missing, want 0", name, expq.size());
         expq.delete();
      end
   endtask

   task automatic test_reset;
      RESET = 1'b1;
      bus.RX_VALID = 1'b0;
      bus.RX_DATA = 8'h00;
      bus.PROCESS_FINISHED = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      total++;
      if ({bus.IRAM_WE, bus.DRAM_WE, bus.IRAM_ADDR, bus.DRAM_ADDR, bus.IRAM_DATA,
           bus.DRAM_DATA, bus.START_PROCESSING_FLAG, bus.LOAD_ERROR, bus.BUSY,
           bus.RX_READY} !== '0) begin
         bad++;
         $display("FAIL reset_outputs: some output nonzero, want all 0");
      end
      RESET = 1'b0;
      @(posedge clk); #1;
      total++;
      if ({bus.RX_READY, bus.BUSY, bus.LOAD_ERROR} !== 3'b100) begin
         bad++;
         $display("FAIL reset_idle: ready/busy/err=%b want 100",
                  {bus.RX_READY, bus.BUSY, bus.LOAD_ERROR});
      end
   endtask

   task automatic test_iram_load;
      pl = '{8'hAA, 8'hBB};
      send_frame(8'h49, 16'h0010, 1'b0);
      drain("iram_load");
      total++;
      if ({bus.LOAD_ERROR, bus.BUSY} !== 2'b00) begin
         bad++;
         $display("FAIL iram_load_err: err/busy=%b want 00", {bus.LOAD_ERROR, bus.BUSY});
      end
   endtask

   task automatic test_dram_wrap;
      pl = '{8'h01, 8'h02, 8'h03};
      send_frame(8'h44, 16'hFFFF, 1'b0);
      drain("dram_wrap");
      total++;
      if (bus.LOAD_ERROR !== 1'b0) begin
         bad++;
         $display("FAIL dram_wrap_err: err=%b want 0", bus.LOAD_ERROR);
      end
   endtask

   task automatic test_bad_chk_then_go;
      pl = '{8'h55};
      send_frame(8'h49, 16'h0000, 1'b1);
      drain("bad_chk");
      total++;
      if (bus.LOAD_ERROR !== 1'b1) begin
         bad++;
         $display("FAIL bad_chk_err: err=%b want 1", bus.LOAD_ERROR);
      end
      // FINISHED already high: GO yields a single-cycle START.
      bus.PROCESS_FINISHED = 1'b1;
      send_byte(8'h47);
      total++;
      if ({bus.LOAD_ERROR, bus.START_PROCESSING_FLAG} !== 2'b01) begin
         bad++;
         $display("FAIL go_clears_err: err/start=%b want 01",
                  {bus.LOAD_ERROR, bus.START_PROCESSING_FLAG});
      end
      @(posedge clk); #1;
      total++;
      if ({bus.START_PROCESSING_FLAG, bus.BUSY} !== 2'b00) begin
         bad++;
         $display("FAIL go_one_cycle: start/busy=%b want 00",
                  {bus.START_PROCESSING_FLAG, bus.BUSY});
      end
      bus.PROCESS_FINISHED = 1'b0;
   endtask

   task automatic test_run;
      int errs;
      errs = 0;
      send_byte(8'h47);
      for (int i = 0; i < 100; i++) begin
         if (i == 50) begin
            bus.RX_DATA  = 8'h12;
            bus.RX_VALID = 1'b1;
         end
         if ({bus.START_PROCESSING_FLAG, bus.RX_READY, bus.BUSY, bus.LOAD_ERROR} !== 4'b1010)
            errs++;
         @(posedge clk); #1;
      end
      total++;
      if (errs != 0) begin
         bad++;
         $display("FAIL run_hold: %0d cycles with start/ready/busy/err wrong, want 0", errs);
      end
      bus.PROCESS_FINISHED = 1'b1;
      @(negedge clk);
      total++;
      if (bus.START_PROCESSING_FLAG !== 1'b1) begin
         bad++;
         $display("FAIL run_before_edge: start=%b want 1", bus.START_PROCESSING_FLAG);
      end
      @(posedge clk); #1;
      bus.PROCESS_FINISHED = 1'b0;
      total++;
      if ({bus.START_PROCESSING_FLAG, bus.RX_READY, bus.LOAD_ERROR} !== 3'b010) begin
         bad++;
         $display("FAIL run_finish: start/ready/err=%b want 010",
                  {bus.START_PROCESSING_FLAG, bus.RX_READY, bus.LOAD_ERROR});
      end
      // The byte held during RUN is taken now, as an invalid command.
      @(posedge clk); #1;
      bus.RX_VALID = 1'b0;
      total++;
      if ({bus.LOAD_ERROR, bus.BUSY} !== 2'b10) begin
         bad++;
         $display("FAIL run_held_byte: err/busy=%b want 10", {bus.LOAD_ERROR, bus.BUSY});
      end
   endtask

   task automatic test_timeout;
      int n;
      send_byte(8'h44);
      total++;
      if (bus.LOAD_ERROR !== 1'b0) begin
         bad++;
         $display("FAIL timeout_cmd_clear: err=%b want 0", bus.LOAD_ERROR);
      end
      send_byte(8'h00);
      n = 0;
      while (bus.LOAD_ERROR !== 1'b1 && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      total++;
      if (n != TO) begin
         bad++;
         $display("FAIL timeout_cycles: err after %0d idle cycles, want %0d", n, TO);
      end
      total++;
      if (bus.BUSY !== 1'b0) begin
         bad++;
         $display("FAIL timeout_idle: busy=%b want 0", bus.BUSY);
      end
      send_byte(8'h12);
      drain("timeout");
      total++;
      if (bus.LOAD_ERROR !== 1'b1) begin
         bad++;
         $display("FAIL timeout_after: err=%b want 1", bus.LOAD_ERROR);
      end
   endtask

   task automatic test_reset_mid;
      wr_t w;
      send_byte(8'h49);
      send_byte(8'h00);
      send_byte(8'h04);
      send_byte(8'h00);
      send_byte(8'h20);
      w.is_d = 1'b0; w.addr = 16'h0020; w.data = 8'h11; expq.push_back(w);
      send_byte(8'h11);
      w.addr = 16'h0021; w.data = 8'h22; expq.push_back(w);
      send_byte(8'h22);
      @(negedge clk); #1;
      RESET = 1'b1;
      #1;
      total++;
      if ({bus.IRAM_WE, bus.DRAM_WE, bus.IRAM_ADDR, bus.DRAM_ADDR, bus.IRAM_DATA,
           bus.DRAM_DATA, bus.START_PROCESSING_FLAG, bus.LOAD_ERROR, bus.BUSY,
           bus.RX_READY} !== '0) begin
         bad++;
         $display("FAIL reset_mid_outputs: some output nonzero, want all 0");
      end
      repeat (2) @(posedge clk);
      #1;
      RESET = 1'b0;
      @(posedge clk); #1;
      pl = '{8'hDE, 8'hAD, 8'hBE};
      send_frame(8'h44, 16'h0100, 1'b0);
      drain("reset_mid");
      total++;
      if ({bus.LOAD_ERROR, bus.BUSY} !== 2'b00) begin
         bad++;
         $display("FAIL reset_mid_reload: err/busy=%b want 00", {bus.LOAD_ERROR, bus.BUSY});
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_iram_load();
      test_dram_wrap();
      test_bad_chk_then_go();
      test_run();
      test_timeout();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
